// File: rtl/fft_host_pkg.sv
// Shared types and constants for the fft host bridge.
//   state_e      : bridge sequencing states
//   DATA_W_DEF   : default real/imag word width
//   ADDR_W_DEF   : default SRAM address width
//   WEA_ALL      : full-word byte-write enable for the SRAM write port
package fft_host_pkg;
  localparam int          DATA_W_DEF = 32;
  localparam int          ADDR_W_DEF = 16;
  localparam logic [3:0]  WEA_ALL    = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_KICK,
    ST_WAIT,
    ST_DRAIN
  } state_e;
endpackage

// File: rtl/fft_skid_fifo.sv
// Two-entry valid/ready FIFO used to absorb SRAM read data during DRAIN.
//   clk, rst_n              : clock, synchronous active-low reset (clears storage)
//   in_valid_i/in_ready_o   : write side handshake, in_data_i payload
//   out_valid_o/out_ready_i : read side handshake, out_data_o head entry
//   count_o                 : number of stored entries (0..2), used for read credit
module fft_skid_fifo #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic [1:0]   count_o
);
  logic [W-1:0] mem_q [2];
  logic         wptr_q, rptr_q;
  logic [1:0]   count_q, count_d;
  logic         push, pop;

  assign in_ready_o  = (count_q != 2'd2);
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = mem_q[rptr_q];
  assign count_o     = count_q;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= in_data_i;
        wptr_q        <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/fft_host_bridge.sv
// Host-side driver for the fft core's SRAM and start/finish interface.
// Loads N_IN complex samples into the real/imag SRAMs, pulses compute_start,
// waits for compute_finish, then streams N_OUT results back out.
//   run_start/busy/run_done      : run control
//   in_valid/in_ready/in_*       : input sample stream (accepted only in LOAD)
//   out_valid/out_ready/out_*    : result stream, out_last on final beat
//   compute_start/compute_finish : fft handshake
//   bus_grant                    : 1 while this block owns the SRAM ports
//   sram_{real,imag}_*0          : write port; sram_{real,imag}_*1 : read port
module fft_host_bridge
  import fft_host_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int N_IN     = 240,
  parameter int OUT_BASE = 240,
  parameter int N_OUT    = 240
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_start,
  output logic              busy,
  output logic              run_done,
  output logic              bus_grant,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_imag,
  output logic              out_last,
  output logic              compute_start,
  input  logic              compute_finish,
  output logic [3:0]        sram_real_wea0,
  output logic [ADDR_W-1:0] sram_real_addr0,
  output logic [DATA_W-1:0] sram_real_wdata0,
  output logic [3:0]        sram_real_wea1,
  output logic [ADDR_W-1:0] sram_real_addr1,
  input  logic [DATA_W-1:0] sram_real_rdata1,
  output logic [3:0]        sram_imag_wea0,
  output logic [ADDR_W-1:0] sram_imag_addr0,
  output logic [DATA_W-1:0] sram_imag_wdata0,
  output logic [3:0]        sram_imag_wea1,
  output logic [ADDR_W-1:0] sram_imag_addr1,
  input  logic [DATA_W-1:0] sram_imag_rdata1
);
  localparam int                FW       = 2*DATA_W + 1;
  localparam logic [ADDR_W-1:0] N_IN_M1  = ADDR_W'(N_IN - 1);
  localparam logic [ADDR_W-1:0] N_OUT_A  = ADDR_W'(N_OUT);
  localparam logic [ADDR_W-1:0] N_OUT_M1 = ADDR_W'(N_OUT - 1);
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(OUT_BASE);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic              inflight_q, inflight_d;      // read issued last cycle, data on rdata1 now
  logic              inflight_last_q, inflight_last_d;
  logic              run_done_q, run_done_d;

  logic              load_hs, rd_issue, pop, last_beat;
  logic [2:0]        credit;
  logic              fifo_in_rdy, fifo_vld;
  logic [1:0]        fifo_cnt;
  logic [FW-1:0]     fifo_wdata, fifo_rdata;

  assign load_hs = (state_q == ST_LOAD) && in_valid;
  assign pop     = fifo_vld && out_ready;

  // Entries buffered plus the read in flight, less the beat leaving this
  // cycle. Counting the departing beat is what lets reads go out every cycle
  // at full rate while still never holding more than two results.
  assign credit   = 3'(fifo_cnt) + 3'(inflight_q) - 3'(pop);
  assign rd_issue = (state_q == ST_DRAIN) && (rd_cnt_q != N_OUT_A) &&
                    (credit < 3'd2) && fifo_in_rdy;
  assign last_beat = pop && fifo_rdata[0];

  assign fifo_wdata = {sram_real_rdata1, sram_imag_rdata1, inflight_last_q};

  fft_skid_fifo #(.W(FW)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (inflight_q),
    .in_ready_o (fifo_in_rdy),
    .in_data_i  (fifo_wdata),
    .out_valid_o(fifo_vld),
    .out_ready_i(out_ready),
    .out_data_o (fifo_rdata),
    .count_o    (fifo_cnt)
  );

  always_comb begin
    state_d         = state_q;
    wr_cnt_d        = wr_cnt_q;
    rd_cnt_d        = rd_cnt_q;
    inflight_d      = rd_issue;
    inflight_last_d = rd_issue && (rd_cnt_q == N_OUT_M1);
    run_done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wr_cnt_d = '0;
        rd_cnt_d = '0;
        if (run_start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (load_hs) begin
          if (wr_cnt_q == N_IN_M1) begin
            wr_cnt_d = '0;
            state_d  = ST_KICK;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      ST_KICK: state_d = ST_WAIT;
      ST_WAIT: if (compute_finish) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (rd_issue) rd_cnt_d = rd_cnt_q + 1'b1;
        if (last_beat) begin
          state_d    = ST_IDLE;
          run_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      wr_cnt_q        <= '0;
      rd_cnt_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      run_done_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_cnt_q        <= wr_cnt_d;
      rd_cnt_q        <= rd_cnt_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      run_done_q      <= run_done_d;
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign run_done      = run_done_q;
  assign bus_grant     = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign in_ready      = (state_q == ST_LOAD);
  assign compute_start = (state_q == ST_KICK);

  // Write port is driven only on an accepted sample; otherwise held at zero.
  assign sram_real_wea0   = load_hs ? WEA_ALL : 4'h0;
  assign sram_imag_wea0   = load_hs ? WEA_ALL : 4'h0;
  assign sram_real_addr0  = load_hs ? wr_cnt_q : '0;
  assign sram_imag_addr0  = load_hs ? wr_cnt_q : '0;
  assign sram_real_wdata0 = load_hs ? in_real : '0;
  assign sram_imag_wdata0 = load_hs ? in_imag : '0;

  assign sram_real_wea1  = 4'h0;
  assign sram_imag_wea1  = 4'h0;
  assign sram_real_addr1 = rd_issue ? (BASE_A + rd_cnt_q) : '0;
  assign sram_imag_addr1 = rd_issue ? (BASE_A + rd_cnt_q) : '0;

  // Gate the head entry so stale FIFO contents never show on the outputs.
  assign out_valid = fifo_vld;
  assign out_real  = fifo_vld ? fifo_rdata[FW-1 -: DATA_W] : '0;
  assign out_imag  = fifo_vld ? fifo_rdata[DATA_W -: DATA_W] : '0;
  assign out_last  = fifo_vld && fifo_rdata[0];
endmodule
